branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Consumes the ALU condition flags {n,v,z} and decides branches. Holds an architectural
//   flag register, evaluates a 3-bit condition code against it, computes the PC-relative
//   target, and sequences a fixed-length pipeline flush on a taken branch.
//   Sits between the execute stage (flag producer) and the fetch/PC-select logic.
// PARAMETERS
//   ASIZE         16  PC / target width in bits
//   OFFSET_W       8  branch offset width, signed two's complement
//   FLUSH_CYCLES   2  cycles flush is held after a taken branch (legal range 1..15)
// PORTS
//   clk         in   1         system clock, all state on rising edge
//   rst         in   1         asynchronous, active-high reset
//   flag_we     in   1         flag_in valid; load flag register this cycle
//   flag_in     in   3         ALU flags {n,v,z} (bit2=n, bit1=v, bit0=z)
//   br_valid    in   1         branch instruction present this cycle
//   br_cond     in   3         condition code (table below)
//   br_offset   in   OFFSET_W  signed offset, relative to pc_in
//   pc_in       in   ASIZE     PC of instruction following the branch
//   stall_in    in   1         pipeline stall; freezes branch evaluation and flush count
//   resolved    out  1         1-cycle pulse: branch evaluated
//   taken       out  1         branch taken (valid with resolved, held until next resolve)
//   target      out  ASIZE     branch target (valid with resolved, held until next resolve)
//   flush       out  1         squash younger pipeline stages
//   busy        out  1         state != IDLE
//   flag_q      out  3         current flag register {n,v,z}
// BEHAVIOUR
//   - Reset (async): state=IDLE, counter=0, flag_q=3'b000, resolved=0, taken=0,
//     target=0, flush=0, busy=0. Reset mid-FLUSH drops flush immediately.
//   - Flag register: flag_q <= flag_in on any edge with flag_we=1, independent of state
//     and stall_in. flag_we=0 holds.
//   - Conditions: 000 EQ z | 001 NE ~z | 010 GT ~z&~n | 011 LT n | 100 GE ~n
//     101 LE n|z | 110 OV v | 111 ALWAYS.
//   - Target = pc_in + sign_extend(br_offset) mod 2^ASIZE (wraps, no overflow flag).
//   - Accept = br_valid & ~stall_in & state==IDLE. On accept at edge t:
//     resolved=1, taken=cond, target=computed, all visible after edge t (1-cycle latency).
//   - Not taken: stay IDLE, no flush. Taken: go FLUSH, counter=FLUSH_CYCLES-1,
//     flush=1 for exactly FLUSH_CYCLES non-stalled cycles following edge t.
//   - FLUSH: counter decrements each edge with stall_in=0; stall_in=1 holds counter and
//     flush=1. Exit to IDLE when counter==0 and stall_in=0. br_valid in FLUSH is a
//     wrong-path instruction: ignored, no resolved pulse.
//   - resolved is a single-cycle pulse; cleared on the next edge regardless of stall_in.
//   - Flags used for evaluation: flag_q (the value before this edge's flag_we update).
// CONFIGURATION
//   FLAG_BYPASS_EN defined: when flag_we and accept coincide, condition uses flag_in
//     (forwarded), flag_q still updates normally.
//   FLAG_BYPASS_EN undefined: condition always uses registered flag_q; a branch in the
//     same cycle as flag_we sees the older flags.
// TESTING
//   1 rst pulse mid-FLUSH -> flush,busy,resolved,taken,target,flag_q all 0 asynchronously.
//   2 flag_we, flag_in=3'b001; next cycle br_valid, cond=000, pc_in=16'h0010,
//     br_offset=8'hFC -> resolved=1, taken=1, target=16'h000C, flush high 2 cycles.
//   3 flag_q=3'b000, cond=011 LT, pc_in=16'hFFFE, br_offset=8'h05 -> taken=0,
//     target=16'h0003 (wrap), no flush, busy=0.
//   4 taken branch, stall_in=1 for 3 cycles inside FLUSH, br_valid=1 throughout ->
//     flush held 2+3 cycles, no extra resolved pulse; br_valid after exit accepted.
//   5 flag_q=3'b000, same cycle flag_we with flag_in=3'b001 and br_valid cond=000 ->
//     FLAG_BYPASS_EN: taken=1; without: taken=0; both: flag_q=3'b001 next cycle.
//   6 all 8 br_cond codes against flag_q in {000,001,010,100,101} -> match table.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Holds the architectural ALU flag register {n,v,z} and resolves branches.
//   A 3-bit condition code is evaluated against the flags. The PC-relative
//   target is computed from pc_in and a sign-extended offset. A taken branch
//   starts a fixed-length pipeline flush that a stall can stretch. The block
//   sits between the execute stage, which produces the flags, and the
//   fetch/PC-select logic.
//
// Parameters:
//   ASIZE        - PC / target width in bits (must exceed OFFSET_W)
//   OFFSET_W     - signed branch offset width
//   FLUSH_CYCLES - non-stalled cycles flush is held after a taken branch (1..15)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   flag_we    in   load flag_in into the flag register this cycle
//   flag_in    in   ALU flags {n,v,z}
//   br_valid   in   branch instruction present this cycle
//   br_cond    in   condition code
//   br_offset  in   signed offset relative to pc_in
//   pc_in      in   PC of the instruction following the branch
//   stall_in   in   pipeline stall; freezes branch acceptance and flush count
//   resolved   out  one-cycle pulse when a branch has been evaluated
//   taken      out  branch outcome, held until the next resolve
//   target     out  branch target, held until the next resolve
//   flush      out  squash younger pipeline stages
//   busy       out  unit is not idle
//   flag_q     out  current flag register {n,v,z}
//
// Configuration:
//   FLAG_BYPASS_EN - when defined, a branch accepted in the same cycle as a
//                    flag write evaluates against flag_in (forwarded) rather
//                    than the older registered flags.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int ASIZE        = 16,
    parameter int OFFSET_W     = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flag_we,
    input  logic [2:0]          flag_in,
    input  logic                br_valid,
    input  logic [2:0]          br_cond,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [ASIZE-1:0]    pc_in,
    input  logic                stall_in,
    output logic                resolved,
    output logic                taken,
    output logic [ASIZE-1:0]    target,
    output logic                flush,
    output logic                busy,
    output logic [2:0]          flag_q
);

    localparam int         EXT_W          = ASIZE - OFFSET_W;
    localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             resolved_q, resolved_d;
    logic             taken_q, taken_d;
    logic [ASIZE-1:0] target_q, target_d;

    logic [2:0]       evalFlags;
    logic             condMet;
    logic             accept;
    logic [ASIZE-1:0] offsetExt;
    logic [ASIZE-1:0] branchTarget;

    // Flags seen by the condition evaluator. With forwarding enabled, a flag
    // write landing on the same edge as the branch is visible to it.
`ifdef FLAG_BYPASS_EN
    assign evalFlags = flag_we ? flag_in : flag_q;
`else
    assign evalFlags = flag_q;
`endif

    // Condition table over {n,v,z} = evalFlags[2:0].
    always_comb begin
        condMet = 1'b0;
        case (br_cond)
            3'b000:  condMet = evalFlags[0];
            3'b001:  condMet = ~evalFlags[0];
            3'b010:  condMet = ~evalFlags[0] & ~evalFlags[2];
            3'b011:  condMet = evalFlags[2];
            3'b100:  condMet = ~evalFlags[2];
            3'b101:  condMet = evalFlags[2] | evalFlags[0];
            3'b110:  condMet = evalFlags[1];
            default: condMet = 1'b1;
        endcase
    end

    // Target arithmetic wraps modulo 2^ASIZE.
    assign offsetExt    = {{EXT_W{br_offset[OFFSET_W-1]}}, br_offset};
    assign branchTarget = pc_in + offsetExt;

    // A branch arriving during FLUSH is on the wrong path and never accepted.
    assign accept = br_valid & ~stall_in & (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resolved_d = 1'b0;
        taken_d    = taken_q;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resolved_d = 1'b1;
                    taken_d    = condMet;
                    target_d   = branchTarget;
                    if (condMet) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_CNT_INIT;
                    end
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            target_q   <= target_d;
        end
    end

    // The flag register updates regardless of state or stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 3'b000;
        end else if (flag_we) begin
            flag_q <= flag_in;
        end
    end

    assign resolved = resolved_q;
    assign taken    = taken_q;
    assign target   = target_q;
    assign flush    = (state_q == FLUSH);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit. A table of branch vectors is
// applied in a loop. The expected {taken, target} of each accepted branch is
// pushed to a scoreboard queue when the branch is driven. A monitor pops and
// compares the entry whenever the DUT pulses resolved. Hand-written sequences
// cover stall inside a flush, same-cycle flag forwarding and reset in the
// middle of a flush.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        flag_we;
    logic [2:0]  flag_in;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [7:0]  br_offset;
    logic [15:0] pc_in;
    logic        stall_in;
    logic        resolved;
    logic        taken;
    logic [15:0] target;
    logic        flush;
    logic        busy;
    logic [2:0]  flag_q;

    typedef struct {
        logic [2:0]  flags;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [7:0]  off;
        logic        expTaken;
        logic [15:0] expTarget;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [15:0] target;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;

`ifdef FLAG_BYPASS_EN
    localparam logic BYP_EXP = 1'b1;
`else
    localparam logic BYP_EXP = 1'b0;
`endif

    branch_resolve_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .pc_in     (pc_in),
        .stall_in  (stall_in),
        .resolved  (resolved),
        .taken     (taken),
        .target    (target),
        .flush     (flush),
        .busy      (busy),
        .flag_q    (flag_q)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // A single comparison. It counts the check and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor. It samples just after each rising edge. Every
    // resolved pulse must match the oldest outstanding expectation, and a
    // pulse with nothing expected is an error.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resolved === 1'b1) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resolved: got 1 expected 0 (taken=%0b target=%0h)", taken, target);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_taken", 32'(taken), 32'(e.taken));
                checkOutput("sb_target", 32'(target), 32'(e.target));
            end
        end
    end

    // Load the flags, issue one branch and check that it resolves. Then
    // measure how long flush stays high.
    task automatic applyStimulus(input vec_t v);
        int cycles;
        @(negedge clk);
        flag_we = 1'b1;
        flag_in = v.flags;
        @(negedge clk);
        flag_we   = 1'b0;
        br_valid  = 1'b1;
        br_cond   = v.cond;
        pc_in     = v.pc;
        br_offset = v.off;
        sbQ.push_back('{v.expTaken, v.expTarget});
        @(negedge clk);
        br_valid = 1'b0;
        checkOutput("flag_q_loaded", 32'(flag_q), 32'(v.flags));
        checkOutput("resolve_seen", sbQ.size(), 0);
        cycles = 0;
        while (flush === 1'b1 && cycles < 20) begin
            checkOutput("busy_in_flush", 32'(busy), 1);
            cycles++;
            @(negedge clk);
        end
        checkOutput("flush_len", cycles, v.expTaken ? 2 : 0);
        checkOutput("busy_after", 32'(busy), 0);
    endtask

    // Main stimulus thread.
    initial begin
        logic [2:0] flagSet[5]   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [7:0] takenMask[5] = '{8'h96, 8'hB1, 8'hD6, 8'hAA, 8'hA9};
        logic [7:0]  m;
        logic [15:0] p;
        logic [7:0]  o;
        int          k;

        rst       = 1'b1;
        flag_we   = 1'b0;
        flag_in   = 3'b000;
        br_valid  = 1'b0;
        br_cond   = 3'b000;
        br_offset = 8'h00;
        pc_in     = 16'h0000;
        stall_in  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_resolved", 32'(resolved), 0);
        checkOutput("rst_taken", 32'(taken), 0);
        checkOutput("rst_target", 32'(target), 0);
        checkOutput("rst_flush", 32'(flush), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_flag_q", 32'(flag_q), 0);
        rst = 1'b0;

        // Hand-picked vectors first, then every condition against each flag set.
        vecs.push_back('{3'b001, 3'b000, 16'h0010, 8'hFC, 1'b1, 16'h000C});
        vecs.push_back('{3'b000, 3'b011, 16'hFFFE, 8'h05, 1'b0, 16'h0003});
        vecs.push_back('{3'b100, 3'b111, 16'h0005, 8'h80, 1'b1, 16'hFF85});
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 8; c++) begin
                m = takenMask[f];
                p = 16'($urandom);
                o = 8'($urandom);
                vecs.push_back('{flagSet[f], 3'(c), p, o, m[c], 16'(p + {{8{o[7]}}, o})});
            end
        end

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Stall inside a flush while a wrong-path branch is held valid. Then
        // check that a branch right after the flush is accepted.
        @(negedge clk);
        flag_we = 1'b1;
        flag_in = 3'b001;
        @(negedge clk);
        flag_we   = 1'b0;
        br_valid  = 1'b1;
        br_cond   = 3'b111;
        pc_in     = 16'h2000;
        br_offset = 8'h80;
        sbQ.push_back('{1'b1, 16'h1F80});
        @(negedge clk);
        k = 0;
        while (flush === 1'b1 && k < 30) begin
            stall_in = (k < 3);
            k++;
            @(negedge clk);
        end
        checkOutput("stall_flush_len", k, 5);
        stall_in  = 1'b0;
        br_cond   = 3'b001;
        pc_in     = 16'h3000;
        br_offset = 8'h04;
        sbQ.push_back('{1'b0, 16'h3004});
        @(negedge clk);
        br_valid = 1'b0;
        checkOutput("post_flush_accept", sbQ.size(), 0);
        checkOutput("post_flush_noflush", 32'(flush), 0);

        // A flag write and a branch on the same edge.
        @(negedge clk);
        flag_we = 1'b1;
        flag_in = 3'b000;
        @(negedge clk);
        flag_in   = 3'b001;
        br_valid  = 1'b1;
        br_cond   = 3'b000;
        pc_in     = 16'h0100;
        br_offset = 8'h10;
        sbQ.push_back('{BYP_EXP, 16'h0110});
        @(negedge clk);
        flag_we  = 1'b0;
        br_valid = 1'b0;
        checkOutput("bypass_flag_q", 32'(flag_q), 3'b001);
        checkOutput("bypass_resolved", sbQ.size(), 0);
        k = 0;
        while (flush === 1'b1 && k < 20) begin
            k++;
            @(negedge clk);
        end
        checkOutput("bypass_flush_len", k, BYP_EXP ? 2 : 0);

        // Reset asserted between edges in the middle of a flush.
        @(negedge clk);
        flag_we = 1'b1;
        flag_in = 3'b010;
        @(negedge clk);
        flag_we   = 1'b0;
        br_valid  = 1'b1;
        br_cond   = 3'b110;
        pc_in     = 16'h4000;
        br_offset = 8'h20;
        sbQ.push_back('{1'b1, 16'h4020});
        @(negedge clk);
        br_valid = 1'b0;
        checkOutput("pre_rst_flush", 32'(flush), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_flush", 32'(flush), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_resolved", 32'(resolved), 0);
        checkOutput("arst_taken", 32'(taken), 0);
        checkOutput("arst_target", 32'(target), 0);
        checkOutput("arst_flag_q", 32'(flag_q), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_flush", 32'(flush), 0);
        checkOutput("sb_empty", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
